// File: rtl/pe_nic_ctrl.sv
// rtl/pe_nic_ctrl.sv - PE network interface: per-VC TX/RX slots, polarity-gated injection, RR delivery
module pe_nic_ctrl #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              cpu_tx_valid,
    output logic              cpu_tx_ready,
    input  logic [DATA_W-1:0] cpu_tx_data,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              cpu_rx_valid,
    input  logic              cpu_rx_ready,
    output logic [DATA_W-1:0] cpu_rx_data,
    output logic [15:0]       tx_count,
    output logic [15:0]       rx_count,
    output logic              vc_err
);

    logic [DATA_W-1:0] tx_buf [2];
    logic [DATA_W-1:0] rx_buf [2];
    logic [1:0]        tx_vld;
    logic [1:0]        rx_vld;
    logic              rx_rr;

    logic tx_vc;
    logic tx_acc;
    logic tx_inj;
    logic rx_acc;
    logic rx_del;
    logic rx_sel;

    // Ready terms come only from registered valids, so a slot cannot drain and refill in one cycle.
    assign tx_vc        = cpu_tx_data[DATA_W-1];
    assign cpu_tx_ready = ~tx_vld[tx_vc];
    assign tx_acc       = cpu_tx_valid & cpu_tx_ready;

    assign net_so = tx_vld[polarity];
    assign net_do = net_so ? tx_buf[polarity] : '0;
    assign tx_inj = net_so & net_ro;

    assign net_ri = ~rx_vld[polarity];
    assign rx_acc = net_si & net_ri;

    // Prefer the slot the pointer names; fall back to the other one when it is empty.
    assign rx_sel       = rx_vld[rx_rr] ? rx_rr : ~rx_rr;
    assign cpu_rx_valid = |rx_vld;
    assign cpu_rx_data  = cpu_rx_valid ? rx_buf[rx_sel] : '0;
    assign rx_del       = cpu_rx_valid & cpu_rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_vld   <= 2'b00;
            rx_vld   <= 2'b00;
            rx_rr    <= 1'b0;
            tx_count <= 16'h0000;
            rx_count <= 16'h0000;
            vc_err   <= 1'b0;
        end else begin
            if (tx_inj) begin
                tx_vld[polarity] <= 1'b0;
                tx_count         <= tx_count + 16'd1;
            end
            if (tx_acc) begin
                tx_vld[tx_vc] <= 1'b1;
            end
            if (rx_del) begin
                rx_vld[rx_sel] <= 1'b0;
                rx_rr          <= ~rx_sel;
            end
            if (rx_acc) begin
                rx_vld[polarity] <= 1'b1;
                rx_count         <= rx_count + 16'd1;
                if (net_di[DATA_W-1] != polarity) begin
                    vc_err <= 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset: every output read is gated by its valid bit.
    always_ff @(posedge clk) begin
        if (tx_acc) begin
            tx_buf[tx_vc] <= cpu_tx_data;
        end
        if (rx_acc) begin
            rx_buf[polarity] <= net_di;
        end
    end

endmodule

// File: tb/tb_pe_nic_ctrl.sv
// tb/tb_pe_nic_ctrl.sv - scoreboard bench for pe_nic_ctrl with a queue-based reference model
module tb_pe_nic_ctrl;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         polarity = 1'b0;
    logic         cpu_tx_valid = 1'b0;
    logic         cpu_tx_ready;
    logic [W-1:0] cpu_tx_data = '0;
    logic         net_so;
    logic         net_ro = 1'b0;
    logic [W-1:0] net_do;
    logic         net_si = 1'b0;
    logic         net_ri;
    logic [W-1:0] net_di = '0;
    logic         cpu_rx_valid;
    logic         cpu_rx_ready = 1'b0;
    logic [W-1:0] cpu_rx_data;
    logic [15:0]  tx_count;
    logic [15:0]  rx_count;
    logic         vc_err;

    int checks = 0;
    int errors = 0;

    pe_nic_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .cpu_tx_valid(cpu_tx_valid), .cpu_tx_ready(cpu_tx_ready), .cpu_tx_data(cpu_tx_data),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
        .cpu_rx_valid(cpu_rx_valid), .cpu_rx_ready(cpu_rx_ready), .cpu_rx_data(cpu_rx_data),
        .tx_count(tx_count), .rx_count(rx_count), .vc_err(vc_err)
    );

    always #5 clk = ~clk;

    // Reference model: one pending-packet queue per VC in each direction (capacity one).
    logic [W-1:0] txq0[$];
    logic [W-1:0] txq1[$];
    logic [W-1:0] rxq0[$];
    logic [W-1:0] rxq1[$];
    logic [15:0]  m_txc = 16'h0000;
    logic [15:0]  m_rxc = 16'h0000;
    logic         m_err = 1'b0;
    logic         m_rr  = 1'b0;

    function automatic int tx_n(input logic v);
        return v ? txq1.size() : txq0.size();
    endfunction

    function automatic int rx_n(input logic v);
        return v ? rxq1.size() : rxq0.size();
    endfunction

    function automatic logic [W-1:0] tx_h(input logic v);
        return v ? txq1[0] : txq0[0];
    endfunction

    function automatic logic [W-1:0] rx_h(input logic v);
        return v ? rxq1[0] : rxq0[0];
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs every cycle, pops expectations on handshakes, then advances the model.
    always @(negedge clk) begin : monitor
        logic         v;
        logic         exp_so;
        logic         exp_rxv;
        logic         sel;
        logic         inj;
        logic         acc;
        logic         del;
        logic         ej;
        logic [W-1:0] got;

        v       = cpu_tx_data[W-1];
        exp_so  = tx_n(polarity) != 0;
        exp_rxv = (rx_n(1'b0) != 0) || (rx_n(1'b1) != 0);
        sel     = (rx_n(m_rr) != 0) ? m_rr : ~m_rr;

        chk("cpu_tx_ready", {63'd0, cpu_tx_ready}, {63'd0, tx_n(v) == 0});
        chk("net_so", {63'd0, net_so}, {63'd0, exp_so});
        chk("net_do", net_do, exp_so ? tx_h(polarity) : '0);
        chk("net_ri", {63'd0, net_ri}, {63'd0, rx_n(polarity) == 0});
        chk("cpu_rx_valid", {63'd0, cpu_rx_valid}, {63'd0, exp_rxv});
        chk("cpu_rx_data", cpu_rx_data, exp_rxv ? rx_h(sel) : '0);
        chk("tx_count", {48'd0, tx_count}, {48'd0, m_txc});
        chk("rx_count", {48'd0, rx_count}, {48'd0, m_rxc});
        chk("vc_err", {63'd0, vc_err}, {63'd0, m_err});

        inj = exp_so && net_ro;
        acc = cpu_tx_valid && (tx_n(v) == 0);
        del = exp_rxv && cpu_rx_ready;
        ej  = net_si && (rx_n(polarity) == 0);

        if (reset) begin
            txq0.delete(); txq1.delete(); rxq0.delete(); rxq1.delete();
            m_txc = 16'h0000;
            m_rxc = 16'h0000;
            m_err = 1'b0;
            m_rr  = 1'b0;
        end else begin
            if (inj) begin
                if (polarity) got = txq1.pop_front(); else got = txq0.pop_front();
                m_txc = m_txc + 16'd1;
            end
            if (acc) begin
                if (v) txq1.push_back(cpu_tx_data); else txq0.push_back(cpu_tx_data);
            end
            if (del) begin
                if (sel) got = rxq1.pop_front(); else got = rxq0.pop_front();
                m_rr = ~sel;
            end
            if (ej) begin
                if (polarity) rxq1.push_back(net_di); else rxq0.push_back(net_di);
                m_rxc = m_rxc + 16'd1;
                if (net_di[W-1] != polarity) m_err = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        polarity = ~polarity;
    endtask

    task automatic idle();
        cpu_tx_valid = 1'b0;
        net_si       = 1'b0;
    endtask

    initial begin : stimulus
        logic done;

        repeat (3) step();
        reset = 1'b0;

        // VC0 packet written in an odd cycle goes out in the next even cycle.
        if (polarity != 1'b1) step();
        cpu_tx_valid = 1'b1; cpu_tx_data = 64'h0000_0000_0000_00AA; net_ro = 1'b1;
        step();
        cpu_tx_valid = 1'b0;
        #2;
        chk("t1_so", {63'd0, net_so}, 64'd1);
        chk("t1_do", net_do, 64'h0000_0000_0000_00AA);
        step();
        #2;
        chk("t1_cnt", {48'd0, tx_count}, 64'd1);
        chk("t1_ready", {63'd0, cpu_tx_ready}, 64'd1);

        // VC1 packet stalled by the router, then released.
        if (polarity != 1'b0) step();
        cpu_tx_valid = 1'b1; cpu_tx_data = 64'h8000_0000_0000_0001; net_ro = 1'b0;
        step();
        cpu_tx_valid = 1'b0;
        repeat (6) step();
        net_ro = 1'b1;
        repeat (3) step();
        #2;
        chk("t2_cnt", {48'd0, tx_count}, 64'd2);

        // Two ejections held until the processor becomes ready.
        if (polarity != 1'b0) step();
        cpu_rx_ready = 1'b0; net_si = 1'b1; net_di = 64'h0000_0000_0000_0005;
        step();
        net_di = 64'h8000_0000_0000_0006;
        step();
        net_si = 1'b0;
        repeat (2) step();
        cpu_rx_ready = 1'b1;
        repeat (3) step();
        #2;
        chk("t3_rxcnt", {48'd0, rx_count}, 64'd2);

        // Wrong-VC inbound packet in an even cycle.
        if (polarity != 1'b0) step();
        net_si = 1'b1; net_di = 64'h8000_0000_0000_0007;
        step();
        net_si = 1'b0;
        repeat (4) step();
        #2;
        chk("t4_vcerr", {63'd0, vc_err}, 64'd1);

        // Reset with both TX slots and one RX slot occupied.
        net_ro = 1'b0; cpu_rx_ready = 1'b0;
        cpu_tx_valid = 1'b1; cpu_tx_data = 64'h0000_0000_0000_1234;
        step();
        cpu_tx_data = 64'h8000_0000_0000_5678;
        step();
        cpu_tx_valid = 1'b0;
        net_si = 1'b1; net_di = {polarity, 63'h0000_0000_0000_0ABC};
        step();
        net_si = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0; net_ro = 1'b1; cpu_rx_ready = 1'b1;
        #2;
        chk("t6_so", {63'd0, net_so}, 64'd0);
        chk("t6_rxv", {63'd0, cpu_rx_valid}, 64'd0);
        chk("t6_txc", {48'd0, tx_count}, 64'd0);
        chk("t6_vcerr", {63'd0, vc_err}, 64'd0);
        repeat (6) step();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step();
            reset        = ($urandom_range(499, 0) == 0);
            cpu_tx_valid = $urandom_range(1, 0) == 1;
            cpu_tx_data  = {$urandom, $urandom};
            net_ro       = $urandom_range(3, 0) != 0;
            net_si       = $urandom_range(1, 0) == 1;
            net_di       = {$urandom, $urandom};
            if ($urandom_range(15, 0) != 0) net_di[W-1] = polarity;
            cpu_rx_ready = $urandom_range(1, 0) == 1;
        end
        reset = 1'b0;
        idle();

        // Back-to-back injections, alternating VCs, until the TX counter wraps.
        net_ro = 1'b1; cpu_rx_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 70000 && !done; i++) begin
            step();
            if (m_txc == 16'hFFFF) begin
                cpu_tx_valid = 1'b0;
                done = 1'b1;
            end else begin
                cpu_tx_valid = 1'b1;
                cpu_tx_data  = {~polarity, 31'd0, $urandom};
            end
        end
        chk("wrap_reached", {63'd0, done}, 64'd1);
        step();
        #2;
        chk("tx_wrap", {48'd0, tx_count}, 64'd0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
